feature_bank_rd: RTL and testbench
==================================

FEATURE_BANK_RD -- requirements
Module: feature_bank_rd

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning external address width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 11, meaning words per bank = 2^DEPTH_LOG2; only addr[DEPTH_LOG2-1:0] is used.
REQ-004 SHALL have parameter READ_LATENCY, default 2, legal 1..4, meaning memory read pipeline stages.
REQ-005 SHALL have ports in this order:
- iclk input 1: clock; all logic on rising edge.
- irst input 1: asynchronous active-low reset.
- wr_en input 1: write strobe into the current write bank.
- wr_addr input ADDR_WIDTH: write address.
- wr_data input DATA_WIDTH: write data.
- rd_req input 1: read request.
- rd_addr input ADDR_WIDTH: read address, sampled with rd_req.
- rd_rdy output 1: request accepted when rd_req&&rd_rdy.
- rd_valid output 1: rd_data holds a returned word.
- rd_data output DATA_WIDTH: read data, in request order.
- rd_ack input 1: consumer takes the word when rd_valid&&rd_ack.
- swap input 1: one-cycle request to exchange banks.
- swap_busy output 1: swap pending or in progress.
- wr_bank output 1: bank index written; the read bank is always ~wr_bank.

Function
REQ-006 SHALL contain two banks of 2^DEPTH_LOG2 x DATA_WIDTH (ping-pong); writes go only to wr_bank, reads only to ~wr_bank.
REQ-007 SHALL write wr_data to wr_addr on any edge with wr_en=1, in every FSM state.
REQ-008 SHALL pipeline reads at one accepted request per cycle, independent of rd_ack.
REQ-009 SHALL carry a valid bit through a READ_LATENCY-deep shift register alongside each read.
REQ-010 SHALL provide an output FIFO of depth READ_LATENCY+2, first-word fall-through.
REQ-011 SHALL drive rd_rdy = (inflight + fifo_count < READ_LATENCY+2) && state==ACTIVE, so the FIFO never overflows.
REQ-012 SHALL assert rd_valid with the matching data no earlier than READ_LATENCY cycles after acceptance; when the FIFO is empty and there is no backpressure, exactly READ_LATENCY cycles.
REQ-013 SHALL hold rd_data and rd_valid stable while rd_valid=1 and rd_ack=0.
REQ-014 SHALL allow a FIFO push and pop on the same edge with no change in count.
REQ-015 SHALL implement the FSM ACTIVE -> DRAIN -> SWAP -> ACTIVE:
- ACTIVE: swap=1 moves to DRAIN.
- DRAIN: rd_rdy=0; moves to SWAP when inflight==0.
- SWAP: one cycle; toggles wr_bank.
REQ-016 SHALL assert swap_busy=1 in DRAIN and SWAP.
REQ-017 SHALL ignore swap pulses while swap_busy=1.
REQ-018 SHALL NOT require the FIFO to be empty to complete a swap; words already read remain valid.
REQ-019 SHALL make a write in the SWAP cycle go to the pre-toggle wr_bank.
REQ-020 SHALL, when swap and rd_req arrive together in ACTIVE, accept the read into the old read bank and begin DRAIN next cycle.
REQ-021 SHALL wrap addresses modulo 2^DEPTH_LOG2, ignoring upper bits.

Reset
REQ-022 SHALL, when irst=0, asynchronously clear to:
- FSM: ACTIVE.
- wr_bank=0, swap_busy=0, rd_valid=0, rd_data=0.
- Pipeline valid bits and FIFO pointers/count: 0.
REQ-023 SHALL leave memory contents undefined after reset.
REQ-024 SHALL drive rd_rdy=0 during reset, and rd_rdy=1 on the first edge after release.
REQ-025 SHALL discard all in-flight reads on reset mid-operation; no rd_valid after release until a new request.

Verification
REQ-026 Write 0x1111 at addr 5, swap, read addr 5 with rd_ack=1 -> rd_valid exactly READ_LATENCY cycles later with rd_data=0x1111.
REQ-027 Back-to-back reads of addrs 0..7 with rd_ack=0 -> rd_rdy drops after READ_LATENCY+2 acceptances; rd_ack=1 then returns data in order with no loss or duplicate.
REQ-028 swap while 2 reads in flight -> swap_busy=1, rd_rdy=0 until reads land; wr_bank toggles one cycle after inflight=0; old-bank data delivered.
REQ-029 Write addr 0x0805 with DEPTH_LOG2=11 -> read of addr 0x0005 returns the word (wrap).
REQ-030 Reset asserted with 3 words in FIFO and 1 in flight -> rd_valid=0 immediately; after release wr_bank=0 and no stale words.
REQ-031 Sweep READ_LATENCY=1 and 4 -> REQ-026 and REQ-027 hold.

Source files
------------

// File: rtl/feature_bank_rd.sv
// Ping-pong feature bank with a pipelined read port and a first-word-fall-through return FIFO.
// Swapping the banks waits until every accepted read has left the memory pipeline.
module feature_bank_rd #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DEPTH_LOG2   = 11,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_rdy,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ack,
  input  logic                  swap,
  output logic                  swap_busy,
  output logic                  wr_bank
);

  localparam int unsigned Depth     = 1 << DEPTH_LOG2;
  localparam int unsigned FifoDepth = READ_LATENCY + 2;
  localparam int unsigned PtrW      = $clog2(FifoDepth);
  localparam int unsigned CntW      = $clog2(FifoDepth + 1);

  typedef enum logic [1:0] {StActive, StDrain, StSwap} state_e;

  state_e                  state_q, state_d;
  logic                    wr_bank_q, wr_bank_d;
  logic                    rdy_en_q;
  logic [DATA_WIDTH-1:0]   mem [2][Depth];
  logic [DEPTH_LOG2-1:0]   wr_idx, rd_idx;
  logic [READ_LATENCY-1:0] pipe_vld_q;
  logic [DATA_WIDTH-1:0]   pipe_data_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   fifo_mem_q [FifoDepth];
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         fifo_cnt_q, inflight;
  logic [CntW:0]           occupancy;
  logic                    accept, push, pop;

  // Upper address bits are deliberately ignored so addresses wrap per bank.
  logic unused_addr;
  assign unused_addr = ^{wr_addr[ADDR_WIDTH-1:DEPTH_LOG2], rd_addr[ADDR_WIDTH-1:DEPTH_LOG2]};

  assign wr_idx    = wr_addr[DEPTH_LOG2-1:0];
  assign rd_idx    = rd_addr[DEPTH_LOG2-1:0];
  assign accept    = rd_req && rd_rdy;
  assign push      = pipe_vld_q[READ_LATENCY-1];
  assign rd_valid  = fifo_cnt_q != '0;
  assign pop       = rd_valid && rd_ack;
  assign rd_data   = rd_valid ? fifo_mem_q[rd_ptr_q] : '0;
  assign wr_bank   = wr_bank_q;
  assign swap_busy = state_q != StActive;
  assign occupancy = {1'b0, inflight} + {1'b0, fifo_cnt_q};
  // Reserving FIFO space at acceptance time keeps the pipeline free of backpressure.
  assign rd_rdy    = rdy_en_q && (state_q == StActive) && (occupancy < (CntW + 1)'(FifoDepth));

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CntW'(pipe_vld_q[i]);
    end
  end

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    case (state_q)
      StActive: if (swap) state_d = StDrain;
      StDrain:  if (inflight == '0) state_d = StSwap;
      StSwap: begin
        state_d   = StActive;
        wr_bank_d = ~wr_bank_q;
      end
      default:  state_d = StActive;
    endcase
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state_q    <= StActive;
      wr_bank_q  <= 1'b0;
      rdy_en_q   <= 1'b0;
      pipe_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      rdy_en_q      <= 1'b1;
      pipe_vld_q[0] <= accept;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
      end
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      fifo_cnt_q <= fifo_cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  // Storage and data path carry no reset; validity is tracked by the control state above.
  always_ff @(posedge iclk) begin
    if (wr_en) mem[wr_bank_q][wr_idx] <= wr_data;
    if (accept) pipe_data_q[0] <= mem[~wr_bank_q][rd_idx];
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_data_q[i] <= pipe_data_q[i-1];
    end
    if (push) fifo_mem_q[wr_ptr_q] <= pipe_data_q[READ_LATENCY-1];
  end

endmodule

// File: tb/tb_feature_bank_rd.sv
// Bench for feature_bank_rd: three instances (latency 1, 2, 4) exercised in turn against a
// transaction-level model that tracks outstanding reads, bank contents and swap timing.
module tb_feature_bank_rd;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int NI = 3;

  logic iclk = 1'b0;
  logic irst = 1'b0;
  logic [NI-1:0] wr_en, rd_req, rd_ack, swap, rd_rdy, rd_valid, swap_busy, wr_bank;
  logic [NI-1:0][AW-1:0] wr_addr, rd_addr;
  logic [NI-1:0][DW-1:0] wr_data, rd_data;

  int errors = 0;
  int checks = 0;

  always #5 iclk = ~iclk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    feature_bank_rd #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .DEPTH_LOG2  (11),
      .READ_LATENCY(Lat)
    ) u_dut (
      .iclk     (iclk),
      .irst     (irst),
      .wr_en    (wr_en[g]),
      .wr_addr  (wr_addr[g]),
      .wr_data  (wr_data[g]),
      .rd_req   (rd_req[g]),
      .rd_addr  (rd_addr[g]),
      .rd_rdy   (rd_rdy[g]),
      .rd_valid (rd_valid[g]),
      .rd_data  (rd_data[g]),
      .rd_ack   (rd_ack[g]),
      .swap     (swap[g]),
      .swap_busy(swap_busy[g]),
      .wr_bank  (wr_bank[g])
    );
  end

  // Reference model: each accepted read is a queue entry stamped with its acceptance edge.
  typedef struct {
    logic [DW-1:0] d;
    bit            known;
    int            e;
  } rd_t;

  rd_t           q[$];
  logic [DW-1:0] mmem [2][2048];
  bit            mknown [2][2048];
  int            n = 0;
  bit            mbank, mbusy, rdy_ok;
  int            toggle_e, last_acc;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  function automatic bit exp_valid(input int k);
    return (q.size() > 0) && (q[0].e + lat(k) <= n);
  endfunction

  function automatic bit exp_rdy(input int k);
    return rdy_ok && !mbusy && (q.size() < lat(k) + 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_all();
    wr_en = '0; rd_req = '0; rd_ack = '0; swap = '0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
  endtask

  task automatic model_reset();
    q.delete();
    mbank = 1'b0; mbusy = 1'b0; rdy_ok = 1'b0; last_acc = -100;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 2048; a++) mknown[b][a] = 1'b0;
  endtask

  task automatic check_outputs(input int k);
    chk("rd_rdy", 32'(rd_rdy[k]), 32'(exp_rdy(k)));
    chk("rd_valid", 32'(rd_valid[k]), 32'(exp_valid(k)));
    if (exp_valid(k) && q[0].known) chk("rd_data", 32'(rd_data[k]), 32'(q[0].d));
    chk("swap_busy", 32'(swap_busy[k]), 32'(mbusy));
    chk("wr_bank", 32'(wr_bank[k]), 32'(mbank));
  endtask

  // Check current outputs, apply the pending inputs to the model, then advance one edge.
  task automatic step(input int k);
    int a;
    bit er, ev;
    check_outputs(k);
    er = exp_rdy(k);
    ev = exp_valid(k);
    if (wr_en[k]) begin
      a = int'(wr_addr[k][10:0]);
      mmem[mbank][a] = wr_data[k];
      mknown[mbank][a] = 1'b1;
    end
    if (ev && rd_ack[k]) void'(q.pop_front());
    if (rd_req[k] && er) begin
      a = int'(rd_addr[k][10:0]);
      q.push_back('{mmem[!mbank][a], mknown[!mbank][a], n + 1});
      last_acc = n + 1;
    end
    if (swap[k] && !mbusy) begin
      mbusy = 1'b1;
      toggle_e = (((n + 1) > (last_acc + lat(k))) ? (n + 1) : (last_acc + lat(k))) + 2;
    end
    @(posedge iclk);
    #1;
    n++;
    if (mbusy && n == toggle_e) begin
      mbank = !mbank;
      mbusy = 1'b0;
    end
    rdy_ok = 1'b1;
  endtask

  task automatic do_reset(input int k);
    irst = 1'b0;
    #1;
    chk("rst_rd_valid", 32'(rd_valid[k]), 32'd0);
    chk("rst_rd_rdy", 32'(rd_rdy[k]), 32'd0);
    chk("rst_swap_busy", 32'(swap_busy[k]), 32'd0);
    chk("rst_wr_bank", 32'(wr_bank[k]), 32'd0);
    chk("rst_rd_data", 32'(rd_data[k]), 32'd0);
    model_reset();
    repeat (2) begin
      @(posedge iclk);
      #1;
      n++;
      chk("rst_hold_rdy", 32'(rd_rdy[k]), 32'd0);
    end
    irst = 1'b1;
  endtask

  task automatic wait_swap(input int k);
    for (int c = 0; c < 20 && mbusy; c++) step(k);
    chk("swap_done", 32'(swap_busy[k]), 32'd0);
  endtask

  task automatic run_instance(input int k);
    int issued, pops;
    idle_all();
    do_reset(k);
    step(k);
    // Fill bank 0 at addresses 0..7, then swap so it becomes the read bank.
    for (int i = 0; i < 8; i++) begin
      wr_en[k] = 1'b1;
      wr_addr[k] = AW'(i);
      wr_data[k] = (i == 5) ? 16'h1111 : DW'(16'h2000 + i);
      step(k);
    end
    wr_en[k] = 1'b0;
    swap[k] = 1'b1;
    step(k);
    swap[k] = 1'b0;
    wait_swap(k);
    // Single read with the consumer always ready.
    rd_req[k] = 1'b1; rd_addr[k] = AW'(5); rd_ack[k] = 1'b1;
    step(k);
    rd_req[k] = 1'b0;
    repeat (lat(k) + 2) step(k);
    // Back-to-back reads into a stalled consumer, then release.
    rd_ack[k] = 1'b0; rd_req[k] = 1'b1; issued = 0; pops = 0;
    for (int c = 0; c < 12; c++) begin
      rd_addr[k] = AW'(issued);
      if (rd_rdy[k]) issued++;
      step(k);
    end
    chk("accepts_before_stall", 32'(issued), 32'(lat(k) + 2));
    rd_ack[k] = 1'b1;
    for (int c = 0; c < 40 && issued < 8; c++) begin
      rd_addr[k] = AW'(issued);
      if (rd_rdy[k]) issued++;
      if (rd_valid[k]) pops++;
      step(k);
    end
    rd_req[k] = 1'b0;
    for (int c = 0; c < lat(k) + 6; c++) begin
      if (rd_valid[k]) pops++;
      step(k);
    end
    chk("all_issued", 32'(issued), 32'd8);
    chk("pops", 32'(pops), 32'd8);
    // Aliased write into the write bank, then swap with reads in flight.
    wr_en[k] = 1'b1; wr_addr[k] = 16'h0805; wr_data[k] = 16'hABCD;
    step(k);
    wr_en[k] = 1'b0;
    rd_req[k] = 1'b1; rd_addr[k] = AW'(1);
    step(k);
    rd_addr[k] = AW'(2); swap[k] = 1'b1;
    step(k);
    rd_req[k] = 1'b0; swap[k] = 1'b0;
    chk("busy_after_swap", 32'(swap_busy[k]), 32'd1);
    chk("rdy_low_in_drain", 32'(rd_rdy[k]), 32'd0);
    wait_swap(k);
    repeat (lat(k) + 2) step(k);
    rd_req[k] = 1'b1; rd_addr[k] = 16'h0005;
    step(k);
    rd_req[k] = 1'b0;
    repeat (lat(k) + 2) step(k);
    // Bring wr_bank to 1, fill the FIFO/pipeline, then reset mid-operation.
    swap[k] = 1'b1;
    step(k);
    swap[k] = 1'b0;
    wait_swap(k);
    chk("wr_bank_before_reset", 32'(wr_bank[k]), 32'd1);
    rd_ack[k] = 1'b0; rd_req[k] = 1'b1; rd_addr[k] = AW'(3);
    repeat (4) step(k);
    idle_all();
    do_reset(k);
    repeat (lat(k) + 3) step(k);
    // Randomized traffic with occasional swaps.
    for (int c = 0; c < 250; c++) begin
      wr_en[k]   = 1'($urandom_range(0, 1));
      wr_addr[k] = AW'($urandom_range(0, 15)) | (AW'($urandom_range(0, 31)) << 11);
      wr_data[k] = DW'($urandom);
      rd_req[k]  = ($urandom_range(0, 3) != 0);
      rd_addr[k] = AW'($urandom_range(0, 15)) | (AW'($urandom_range(0, 31)) << 11);
      rd_ack[k]  = 1'($urandom_range(0, 1));
      swap[k]    = ($urandom_range(0, 15) == 0);
      step(k);
    end
    idle_all();
    rd_ack[k] = 1'b1;
    wait_swap(k);
    repeat (lat(k) + 4) step(k);
    chk("drained", 32'(rd_valid[k]), 32'd0);
  endtask

  initial begin
    idle_all();
    model_reset();
    for (int k = 0; k < NI; k++) run_instance(k);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
